// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I memory funct3 codes, FSM state
// encodings and small access-size helpers used by the FSM and the lane steering.
package lsu_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    localparam logic [2:0] LSU_IDLE = 3'd0;
    localparam logic [2:0] LSU_REQ  = 3'd1;
    localparam logic [2:0] LSU_WAIT = 3'd2;
    localparam logic [2:0] LSU_DONE = 3'd3;
    localparam logic [2:0] LSU_EXC  = 3'd4;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    // Reserved encodings 011/110/111 fall through to word accesses.
    function automatic size_e access_size(input logic [2:0] funct3);
        size_e sz;
        case (funct3[1:0])
            2'b00:   sz = SIZE_B;
            2'b01:   sz = SIZE_H;
            default: sz = SIZE_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
        logic mis;
        case (access_size(funct3))
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [1:0] natural_align(input logic [2:0] funct3, input logic [1:0] lo);
        logic [1:0] al;
        case (access_size(funct3))
            SIZE_B:  al = lo;
            SIZE_H:  al = {lo[1], 1'b0};
            default: al = 2'b00;
        endcase
        return al;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated store data, and
// load data right-shift plus sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [DWIDTH-1:0] rdata,
    output logic [3:0]        be,
    output logic [DWIDTH-1:0] lane_wdata,
    output logic [DWIDTH-1:0] rdata_ext
);

    logic [DWIDTH-1:0] shifted_s;
    logic              sext_s;

    // Lane steering and load extension for the current access size.
    always_comb begin
        shifted_s  = rdata >> {addr_lo, 3'b000};
        sext_s     = ~funct3[2];
        be         = 4'b0000;
        lane_wdata = wdata;
        rdata_ext  = shifted_s;
        case (access_size(funct3))
            SIZE_B: begin
                be         = we ? (4'b0001 << addr_lo) : 4'b0000;
                lane_wdata = {(DWIDTH/8){wdata[7:0]}};
                rdata_ext  = {{(DWIDTH-8){sext_s & shifted_s[7]}}, shifted_s[7:0]};
            end
            SIZE_H: begin
                be         = we ? (4'b0011 << addr_lo) : 4'b0000;
                lane_wdata = {(DWIDTH/16){wdata[15:0]}};
                rdata_ext  = {{(DWIDTH-16){sext_s & shifted_s[15]}}, shifted_s[15:0]};
            end
            default: begin
                be         = we ? 4'b1111 : 4'b0000;
                lane_wdata = wdata;
                rdata_ext  = shifted_s;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one transaction at a time over a gnt/rvalid memory port.
// Build option LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
module lsu
    import lsu_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_data,
    output logic [4:0]        resp_rd,
    output logic              exc_valid,
    output logic [AWIDTH-1:0] exc_addr
);

    logic [2:0]        state_r, state_n;
    logic              req_ready_r, mem_req_r, resp_valid_r;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [1:0]        addr_lo_r;
    logic [4:0]        rd_r, resp_rd_r;
    logic [3:0]        mem_we_r;
    logic [AWIDTH-1:0] mem_addr_r;
    logic [DWIDTH-1:0] mem_wdata_r, resp_data_r;
    logic              idle_s, accept_s, misalign_s, load_done_s;
    logic              al_we_s;
    logic [2:0]        al_funct3_s;
    logic [1:0]        al_lo_raw_s, al_lo_s;
    logic [3:0]        be_s;
    logic [DWIDTH-1:0] lane_wdata_s, rdata_ext_s;

    assign idle_s      = (state_r == LSU_IDLE);
    assign accept_s    = req_valid & idle_s;
    assign load_done_s = (state_r == LSU_WAIT) & mem_rvalid;

    // The aligner sees the incoming request while idle, the latched one afterwards.
    assign al_we_s     = idle_s ? req_we        : we_r;
    assign al_funct3_s = idle_s ? req_funct3    : funct3_r;
    assign al_lo_raw_s = idle_s ? req_addr[1:0] : addr_lo_r;

`ifdef LSU_MISALIGN_TRAP_EN
    assign al_lo_s    = al_lo_raw_s;
    assign misalign_s = is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign al_lo_s    = natural_align(al_funct3_s, al_lo_raw_s);
    assign misalign_s = 1'b0;
`endif

    lsu_align #(.DWIDTH(DWIDTH)) u_align (
        .we         (al_we_s),
        .funct3     (al_funct3_s),
        .addr_lo    (al_lo_s),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (be_s),
        .lane_wdata (lane_wdata_s),
        .rdata_ext  (rdata_ext_s)
    );

    // Next-state decode.
    always_comb begin
        state_n = state_r;
        case (state_r)
            LSU_IDLE: state_n = accept_s ? (misalign_s ? LSU_EXC : LSU_REQ) : LSU_IDLE;
            LSU_REQ:  state_n = mem_gnt ? (we_r ? LSU_DONE : LSU_WAIT) : LSU_REQ;
            LSU_WAIT: state_n = mem_rvalid ? LSU_DONE : LSU_WAIT;
            LSU_DONE: state_n = LSU_IDLE;
            default:  state_n = LSU_IDLE;
        endcase
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= LSU_IDLE;
            req_ready_r  <= 1'b1;
            mem_req_r    <= 1'b0;
            resp_valid_r <= 1'b0;
            we_r         <= 1'b0;
            funct3_r     <= 3'b000;
            addr_lo_r    <= 2'b00;
            rd_r         <= 5'd0;
            mem_we_r     <= 4'b0000;
            mem_addr_r   <= {AWIDTH{1'b0}};
            mem_wdata_r  <= {DWIDTH{1'b0}};
            resp_data_r  <= {DWIDTH{1'b0}};
            resp_rd_r    <= 5'd0;
        end else begin
            state_r      <= state_n;
            req_ready_r  <= (state_n == LSU_IDLE);
            mem_req_r    <= (state_n == LSU_REQ);
            resp_valid_r <= (state_n == LSU_DONE);
            resp_data_r  <= load_done_s ? rdata_ext_s : {DWIDTH{1'b0}};
            resp_rd_r    <= load_done_s ? rd_r : 5'd0;
            if (accept_s) begin
                we_r        <= req_we;
                funct3_r    <= req_funct3;
                addr_lo_r   <= req_addr[1:0];
                rd_r        <= req_rd;
                mem_we_r    <= be_s;
                mem_addr_r  <= {req_addr[AWIDTH-1:2], 2'b00};
                mem_wdata_r <= lane_wdata_s;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic              exc_valid_r;
    logic [AWIDTH-1:0] exc_addr_r;

    // One-cycle misalignment report; EXC is only entered straight from an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_valid_r <= 1'b0;
            exc_addr_r  <= {AWIDTH{1'b0}};
        end else begin
            exc_valid_r <= (state_n == LSU_EXC);
            exc_addr_r  <= (state_n == LSU_EXC) ? req_addr : {AWIDTH{1'b0}};
        end
    end

    assign exc_valid = exc_valid_r;
    assign exc_addr  = exc_addr_r;
`else
    assign exc_valid = 1'b0;
    assign exc_addr  = {AWIDTH{1'b0}};
`endif

    assign req_ready  = req_ready_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_rd    = resp_rd_r;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the execute-to-memory stage, directly downstream of the integer ALU.
- Takes the ALU `sum` output as the effective address for RV32I loads and stores.
- Handles one memory transaction at a time over a grant/rvalid data-memory port.
- Steers store bytes onto the bus and aligns/extends load data, then returns a one-cycle response to writeback.

Parameters:
- AWIDTH, 32, address width; req_addr and mem_addr width.
- DWIDTH, 32, data width; fixed at 32 for RV32I, byte-lane count = DWIDTH/8.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  execute stage presents a load/store
- req_ready  out  1  LSU can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (byte/half/word, signed/unsigned)
- req_addr  in  AWIDTH  effective address (ALU sum)
- req_wdata  in  DWIDTH  store data (rs2), right-justified
- req_rd  in  5  destination register tag for loads
- mem_req  out  1  memory request pending
- mem_we  out  4  byte write enables, 0000 for loads
- mem_addr  out  AWIDTH  word-aligned address, bits [1:0] = 00
- mem_wdata  out  DWIDTH  lane-shifted store data
- mem_gnt  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  DWIDTH  raw word read
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DWIDTH  extended load result; 0 for stores
- resp_rd  out  5  tag of completed op; 0 for stores
- exc_valid  out  1  misaligned-access pulse (see Optional Feature)
- exc_addr  out  AWIDTH  faulting address

Behaviour:
- States: IDLE, REQ, WAIT, DONE, EXC. Reset (asynchronous) enters IDLE.
- Reset values: every output is 0 except req_ready, which is 1. All latched fields are cleared.
- req_ready = 1 only in IDLE.
- Accept occurs when req_valid && req_ready. The LSU latches we, funct3, addr, wdata and rd.
  - Misaligned request: next state is EXC.
  - Otherwise: next state is REQ.
- Misaligned means:
  - halfword (funct3[1:0]=01) with addr[0]=1;
  - word (funct3[1:0]=10) with addr[1:0]≠00.
- REQ:
  - mem_req = 1, driven from registered state only, with no combinational path from req_*.
  - mem_addr, mem_we and mem_wdata are held stable until mem_gnt.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid, mem_rdata is shifted right by 8×addr[1:0], then extended:
    - LB/LH (000/001) sign-extend;
    - LBU/LHU (100/101) zero-extend;
    - LW (010) passes the word through.
  - The result is registered into resp_data and the state goes to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE. Back-to-back throughput is one op per 3 cycles (store) or 4+ cycles (load).
- EXC: exc_valid = 1 and exc_addr = latched addr for one cycle, with no memory access, then IDLE.
- Store lanes:
  - SB: mem_we = 0001 << addr[1:0], byte replicated on all 4 lanes.
  - SH: mem_we = 0011 << addr[1:0], half replicated on both halves.
  - SW: mem_we = 1111.
- funct3 values 011/110/111 are treated as word access, unsigned.
- mem_gnt or mem_rvalid outside the state expecting it is ignored.
- mem_rvalid in the same cycle as mem_gnt is not supported; memory returns data at least one cycle after grant.
- rst asserted mid-transaction aborts immediately with no response pulse. The memory side must tolerate the abandoned request.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: behaviour as above; misaligned accesses take EXC and pulse exc_valid.
- Undefined:
  - no misalignment check and no EXC state;
  - exc_valid and exc_addr are tied to 0;
  - the low address bits are forced to natural alignment (halfword clears addr[0], word clears addr[1:0]) before lane and shift computation;
  - the access proceeds normally.

Decomposition:
- Shared header opcode.vh (alongside the existing FNC_* ALU codes) gains:
  - FNC_LB/LH/LW/LBU/LHU and FNC_SB/SH/SW;
  - state encodings LSU_IDLE..LSU_EXC.
- One combinational sub-module, lsu_align. It computes mem_we/mem_wdata from (funct3, addr[1:0], wdata) and the extended load value from (funct3, addr[1:0], rdata). The top level holds the FSM and registers.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, mem_gnt 1 cycle after mem_req -> mem_addr=0x100, mem_we=1111, mem_wdata=0xDEADBEEF; resp_valid pulses with resp_data=0, resp_rd=0.
- SB addr=0x103, wdata=0x000000A5 -> mem_we=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x102 rd=7, mem_rdata=0x12F0_3456 -> resp_data=0xFFFFFFF0, resp_rd=7. The same read as LBU -> resp_data=0x000000F0.
- LH addr=0x102, mem_rdata=0x8001_0000, gnt delayed 3 cycles and rvalid 2 cycles later -> mem_req held 4 cycles with stable outputs, resp_data=0xFFFF8001, req_ready low throughout.
- LW addr=0x101:
  - with LSU_MISALIGN_TRAP_EN: mem_req never asserts, exc_valid=1 with exc_addr=0x101 for one cycle.
  - without it: mem_addr=0x100 and a normal response.
- rst asserted while in WAIT -> next cycle req_ready=1, mem_req=0, resp_valid=0; a later mem_rvalid is ignored and no response is produced.
